// File: rtl/hit_event_scheduler_if.sv
// Event handshake between hit_event_scheduler (master) and the game-state
// logic (slave). An event is transferred on a cycle where ev_valid and
// ev_ready are both high; ev_id names the event class.
interface hit_event_scheduler_if #(
   parameter int N_EVENTS = 21,
   parameter int IDW      = $clog2(N_EVENTS)
);

   logic           ev_valid;
   logic           ev_ready;
   logic [IDW-1:0] ev_id;

   modport master (
      output ev_valid,
      output ev_id,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_id,
      output ev_ready
   );

endinterface

// File: rtl/hit_event_scheduler.sv
// hit_event_scheduler
// Collects one-cycle collision pulses into sticky per-event flags over a
// frame, snapshots them into a serve vector at start of frame, and issues
// every pending event exactly once over a valid/ready handshake. The next
// event is chosen round-robin, so no event class can starve the others.
module hit_event_scheduler #(
   parameter int N_EVENTS = 21,
   parameter int IDW      = $clog2(N_EVENTS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  startOfFrame,
   input  logic [N_EVENTS-1:0]   coll_in,
   hit_event_scheduler_if.master ev_bus,
   output logic                  busy,
   output logic                  overrun
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARB     = 2'd1,
      PRESENT = 2'd2
   } state_t;

   localparam logic [IDW-1:0]      LAST_ID  = IDW'(N_EVENTS - 1);
   localparam logic [N_EVENTS-1:0] ONE_HOT0 = N_EVENTS'(1);

   state_t              state_q;
   state_t              state_nxt;

   logic [N_EVENTS-1:0] accum_q;
   logic [N_EVENTS-1:0] accum_nxt;
   logic [N_EVENTS-1:0] serve_q;
   logic [N_EVENTS-1:0] serve_nxt;
   logic [N_EVENTS-1:0] serve_kept;
   logic [N_EVENTS-1:0] clr;

   logic [IDW-1:0]      ptr_q;
   logic [IDW-1:0]      ptr_nxt;
   logic [IDW-1:0]      pick;

   logic                valid_q;
   logic                valid_nxt;
   logic [IDW-1:0]      id_q;
   logic [IDW-1:0]      id_nxt;

   logic                overrun_q;
   logic                busy_q;
   logic                handshake;

   // First set bit of vec at or above start, wrapping from the last event
   // back to event 0. Returns 0 for an empty vector; the FSM never asks then.
   function automatic logic [IDW-1:0] rr_pick(
      input logic [N_EVENTS-1:0] vec,
      input logic [IDW-1:0]      start
   );
      logic [IDW-1:0] idx;
      logic           found;
      rr_pick = '0;
      found   = 1'b0;
      idx     = start;
      for (int off = 0; off < N_EVENTS; off++) begin
         if (!found && vec[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
         idx = (idx == LAST_ID) ? '0 : idx + IDW'(1);
      end
   endfunction

   // Handshake clear, frame merge of accum into serve, and pointer advance.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      handshake  = valid_q & ev_bus.ev_ready;
      clr        = handshake ? (ONE_HOT0 << id_q) : '0;
      serve_kept = serve_q & ~clr;
      accum_nxt  = accum_q | coll_in;
      serve_nxt  = serve_kept;
      ptr_nxt    = ptr_q;

      // The accepted event is cleared before the merge, so a re-collected
      // copy of that same event survives as a fresh pending bit.
      if (startOfFrame) begin
         accum_nxt = coll_in;
         serve_nxt = serve_kept | accum_q;
      end

      if (handshake) begin
         ptr_nxt = (id_q == LAST_ID) ? '0 : id_q + IDW'(1);
      end
   end

   // Round-robin choice over the current serve vector.
   always_comb pick = rr_pick(serve_q, ptr_q);

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is assigned with <= so every register samples
      // pre-edge values regardless of statement order.
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // FSM next state and the next values of the presented event.
   always_comb begin
      state_nxt = state_q;
      valid_nxt = valid_q;
      id_nxt    = id_q;

      unique case (state_q)
         IDLE: begin
            valid_nxt = 1'b0;
            // Looking at the post-merge vector lets a start-of-frame load
            // and the move to ARB happen on the same edge.
            if (serve_nxt != '0) begin
               state_nxt = ARB;
            end
         end
         ARB: begin
            id_nxt    = pick;
            valid_nxt = 1'b1;
            state_nxt = PRESENT;
         end
         PRESENT: begin
            if (ev_bus.ev_ready) begin
               valid_nxt = 1'b0;
               state_nxt = (serve_nxt != '0) ? ARB : IDLE;
            end
         end
         default: begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Flag vectors, pointer and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         accum_q   <= '0;
         serve_q   <= '0;
         ptr_q     <= '0;
         valid_q   <= 1'b0;
         id_q      <= '0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         accum_q   <= accum_nxt;
         serve_q   <= serve_nxt;
         ptr_q     <= ptr_nxt;
         valid_q   <= valid_nxt;
         id_q      <= id_nxt;
         // Still-unserved events at the merge mean a frame's worth of hits
         // was folded into an older one; only the presence is kept.
         overrun_q <= startOfFrame & (serve_kept != '0);
         busy_q    <= (serve_nxt != '0) | valid_nxt;
      end
   end

   assign ev_bus.ev_valid = valid_q;
   assign ev_bus.ev_id    = id_q;
   assign busy            = busy_q;
   assign overrun         = overrun_q;

endmodule

// File: tb/tb_hit_event_scheduler.sv
// Testbench for hit_event_scheduler: directed frame scenarios followed by
// randomized traffic, all checked every cycle against a set-based model of
// pending events, round-robin order and overrun reporting.
module tb_hit_event_scheduler;

   localparam int N   = 21;
   localparam int IDW = $clog2(N);

   logic         clk = 1'b0;
   logic         reset;
   logic         startOfFrame;
   logic [N-1:0] coll_in;
   logic         busy;
   logic         overrun;

   hit_event_scheduler_if #(.N_EVENTS(N), .IDW(IDW)) ev_bus ();

   hit_event_scheduler #(.N_EVENTS(N), .IDW(IDW)) dut (
      .clk          (clk),
      .reset        (reset),
      .startOfFrame (startOfFrame),
      .coll_in      (coll_in),
      .ev_bus       (ev_bus),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: sets of collected and pending events, the round-robin
   // start position, and the overrun flag expected this cycle.
   bit [N-1:0] m_accum     = '0;
   bit [N-1:0] m_pend      = '0;
   bit [N-1:0] m_pend_prev = '0;
   int         m_ptr       = 0;
   bit         m_ovr       = 1'b0;
   int         issued [N];

   // Previous-cycle observations for the pick and hold checks.
   bit         prev_valid = 1'b0;
   bit         prev_ready = 1'b0;
   int         held_id    = 0;

   // Outputs sampled in the most recent cycle.
   logic           obs_valid;
   logic           obs_busy;
   logic           obs_ovr;
   logic [IDW-1:0] obs_id;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit [N-1:0] onehot(input int i);
      bit [N-1:0] v;
      v = N'(1) << i;
      return v;
   endfunction

   // Next pending event at or after p, wrapping; -1 if nothing is pending.
   function automatic int rr_first(input bit [N-1:0] v, input int p);
      int         idx;
      bit [N-1:0] s;
      for (int k = 0; k < N; k++) begin
         idx = (p + k) % N;
         s   = v >> idx;
         if (s[0]) return idx;
      end
      return -1;
   endfunction

   // One clock: sample outputs mid-cycle, compare with the model, advance the
   // model with this cycle's inputs, then return just after the next edge.
   task automatic cycle();
      bit         hs;
      bit [N-1:0] clr;
      bit [N-1:0] kept;
      @(negedge clk);
      obs_valid = ev_bus.ev_valid;
      obs_id    = ev_bus.ev_id;
      obs_busy  = busy;
      obs_ovr   = overrun;

      check("overrun", obs_ovr, m_ovr);
      check("busy", obs_busy, (m_pend != '0) || obs_valid);
      if (obs_valid && !prev_valid) check("pick", obs_id, rr_first(m_pend_prev, m_ptr));
      if (obs_valid && prev_valid && !prev_ready) check("hold_id", obs_id, held_id);

      hs = obs_valid && ev_bus.ev_ready;
      if (reset) begin
         m_accum     = '0;
         m_pend      = '0;
         m_pend_prev = '0;
         m_ptr       = 0;
         m_ovr       = 1'b0;
      end else begin
         clr         = hs ? onehot(int'(obs_id)) : '0;
         kept        = m_pend & ~clr;
         m_pend_prev = m_pend;
         m_ovr       = startOfFrame && (kept != '0);
         if (startOfFrame) begin
            m_pend  = kept | m_accum;
            m_accum = coll_in;
         end else begin
            m_pend  = kept;
            m_accum = m_accum | coll_in;
         end
         if (hs) begin
            m_ptr = (int'(obs_id) + 1) % N;
            if (int'(obs_id) < N) issued[int'(obs_id)]++;
         end
      end
      prev_valid = obs_valid;
      prev_ready = ev_bus.ev_ready;
      held_id    = int'(obs_id);
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input bit sof, input bit [N-1:0] coll, input bit rdy);
      startOfFrame    = sof;
      coll_in         = coll;
      ev_bus.ev_ready = rdy;
      cycle();
   endtask

   // Accept everything until the block goes quiet, with a cycle budget.
   task automatic drain();
      int n;
      n = 0;
      do begin
         tick(1'b0, '0, 1'b1);
         n++;
      end while ((obs_busy || obs_valid) && n < 200);
      check("drain_idle", obs_busy, 1'b0);
   endtask

   initial begin
      bit         r_sof;
      bit         r_rdy;
      bit         seen;
      bit [N-1:0] r_coll;

      reset           = 1'b1;
      startOfFrame    = 1'b0;
      coll_in         = '0;
      ev_bus.ev_ready = 1'b0;
      foreach (issued[i]) issued[i] = 0;
      @(posedge clk);
      #1;

      // Reset state.
      tick(1'b0, '0, 1'b0);
      tick(1'b0, '0, 1'b0);
      check("rst_valid", obs_valid, 1'b0);
      check("rst_id", obs_id, 0);
      check("rst_busy", obs_busy, 1'b0);
      check("rst_ovr", obs_ovr, 1'b0);
      reset = 1'b0;

      // Single event pulsed five times in one frame, issued once.
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, onehot(3), 1'b1);
         tick(1'b0, '0, 1'b1);
      end
      check("se_busy_pre", obs_busy, 1'b0);
      tick(1'b1, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      check("se_t1_valid", obs_valid, 1'b0);
      tick(1'b0, '0, 1'b1);
      check("se_t2_valid", obs_valid, 1'b1);
      check("se_t2_id", obs_id, 3);
      tick(1'b0, '0, 1'b1);
      check("se_t3_valid", obs_valid, 1'b0);
      check("se_t3_busy", obs_busy, 1'b0);

      // Accept event 7 alone so the pointer sits at 8.
      tick(1'b0, onehot(7), 1'b1);
      tick(1'b1, '0, 1'b1);
      drain();

      // Round-robin: {2,7,20} from pointer 8 issues 20, 2, 7.
      tick(1'b0, onehot(2) | onehot(7) | onehot(20), 1'b1);
      tick(1'b1, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      check("rr_t2_id", obs_id, 20);
      check("rr_t2_valid", obs_valid, 1'b1);
      tick(1'b0, '0, 1'b1);
      check("rr_t3_bubble", obs_valid, 1'b0);
      tick(1'b0, '0, 1'b1);
      check("rr_t4_id", obs_id, 2);
      tick(1'b0, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      check("rr_t6_id", obs_id, 7);
      check("rr_t6_valid", obs_valid, 1'b1);
      tick(1'b0, '0, 1'b1);
      check("rr_t7_busy", obs_busy, 1'b0);

      // Pointer left at 8: {3,8} must issue 8 first.
      tick(1'b0, onehot(3) | onehot(8), 1'b1);
      tick(1'b1, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      check("rr_ptr8_id", obs_id, 8);
      drain();

      // Wrap: pointer at 20 with only event 0 pending picks 0.
      tick(1'b0, onehot(19), 1'b1);
      tick(1'b1, '0, 1'b1);
      drain();
      tick(1'b0, onehot(0), 1'b1);
      tick(1'b1, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      check("wrap_valid", obs_valid, 1'b1);
      check("wrap_id", obs_id, 0);
      drain();

      // Backpressure: ten refused cycles, accept on the eleventh.
      tick(1'b0, onehot(5) | onehot(6), 1'b1);
      tick(1'b1, '0, 1'b0);
      tick(1'b0, '0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, '0, 1'b0);
         check("bp_valid", obs_valid, 1'b1);
         check("bp_id", obs_id, 5);
      end
      tick(1'b0, '0, 1'b1);
      check("bp_acc_id", obs_id, 5);
      tick(1'b0, '0, 1'b1);
      check("bp_bubble", obs_valid, 1'b0);
      tick(1'b0, '0, 1'b1);
      check("bp_next_valid", obs_valid, 1'b1);
      check("bp_next_id", obs_id, 6);
      drain();

      // Overrun: {1,4} unserved when {4,9} is merged.
      tick(1'b0, onehot(1) | onehot(4), 1'b0);
      tick(1'b1, '0, 1'b0);
      tick(1'b0, onehot(4) | onehot(9), 1'b0);
      tick(1'b0, '0, 1'b0);
      tick(1'b0, '0, 1'b0);
      tick(1'b1, '0, 1'b0);
      check("ovr_at_sof", obs_ovr, 1'b0);
      tick(1'b0, '0, 1'b0);
      check("ovr_pulse", obs_ovr, 1'b1);
      tick(1'b0, '0, 1'b0);
      check("ovr_once", obs_ovr, 1'b0);
      foreach (issued[i]) issued[i] = 0;
      drain();
      check("ovr_cnt1", issued[1], 1);
      check("ovr_cnt4", issued[4], 1);
      check("ovr_cnt9", issued[9], 1);

      // Start of frame with empty accum while idle; the same-cycle pulse on 5
      // belongs to the next frame.
      tick(1'b1, onehot(5), 1'b1);
      tick(1'b0, '0, 1'b1);
      check("sof0_busy1", obs_busy, 1'b0);
      tick(1'b0, '0, 1'b1);
      check("sof0_valid2", obs_valid, 1'b0);
      check("sof0_busy2", obs_busy, 1'b0);
      tick(1'b1, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      check("next_frame_valid", obs_valid, 1'b1);
      check("next_frame_id", obs_id, 5);
      drain();

      // Accept 5 on the same edge as a merge that re-adds only 5.
      tick(1'b0, onehot(5), 1'b0);
      tick(1'b1, '0, 1'b0);
      tick(1'b0, '0, 1'b0);
      tick(1'b0, onehot(5), 1'b0);
      check("same_pres_id", obs_id, 5);
      tick(1'b1, '0, 1'b1);
      tick(1'b0, '0, 1'b1);
      check("same_no_ovr", obs_ovr, 1'b0);
      check("same_bubble", obs_valid, 1'b0);
      tick(1'b0, '0, 1'b1);
      check("same_reissue_valid", obs_valid, 1'b1);
      check("same_reissue_id", obs_id, 5);
      drain();

      // Two-cycle reset while an event is presented; collected hits are lost.
      tick(1'b0, onehot(10) | onehot(11), 1'b0);
      tick(1'b1, onehot(12), 1'b0);
      tick(1'b0, '0, 1'b0);
      tick(1'b0, '0, 1'b0);
      check("mid_present", obs_valid, 1'b1);
      reset = 1'b1;
      tick(1'b0, '0, 1'b0);
      tick(1'b0, '0, 1'b0);
      check("midrst_valid", obs_valid, 1'b0);
      check("midrst_id", obs_id, 0);
      check("midrst_busy", obs_busy, 1'b0);
      check("midrst_ovr", obs_ovr, 1'b0);
      reset = 1'b0;
      seen  = 1'b0;
      tick(1'b1, '0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, '0, 1'b1);
         seen = seen | obs_valid;
      end
      check("midrst_no_issue", seen, 1'b0);

      // Randomized traffic, checked cycle by cycle against the model.
      for (int c = 0; c < 4000; c++) begin
         r_sof  = ($urandom_range(0, 14) == 0);
         r_coll = '0;
         if ($urandom_range(0, 3) == 0) r_coll = onehot(int'($urandom_range(0, N - 1)));
         if ($urandom_range(0, 15) == 0) r_coll = r_coll | onehot(int'($urandom_range(0, N - 1)));
         r_rdy  = ($urandom_range(0, 9) < 7);
         reset  = (c == 2500);
         tick(r_sof, r_coll, r_rdy);
      end
      reset = 1'b0;

      // Flush what is still collected, then everything must be served.
      tick(1'b1, '0, 1'b1);
      drain();
      check("final_valid", obs_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hit_event_scheduler.md
# hit_event_scheduler

Frame-level scheduler sitting between the per-pixel collision detector and the game-state logic. The detector raises its collision outputs for one cycle on each overlapping pixel, many times per frame and in raster order. This block does three things with those pulses:
- Accumulates them into sticky per-event flags during a frame.
- Snapshots the flags at start of frame.
- Issues each pending event exactly once to the game logic over a valid/ready handshake, using round-robin arbitration so no event class starves.

## Interface
- N_EVENTS, 21, number of collision event lines (one per detector output)
- IDW, $clog2(N_EVENTS), width of the event index
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; all state cleared on the rising edge of clk while high
- startOfFrame  in  1  single-cycle pulse at frame boundary
- coll_in  in  N_EVENTS  collision pulses; bit i = event i (index order fixed by the top-level)
- ev_ready  in  1  consumer accepts the presented event this cycle
- ev_valid  out  1  event presented on ev_id
- ev_id  out  IDW  index of presented event, 0..N_EVENTS-1
- busy  out  1  serve vector non-empty or event in flight
- overrun  out  1  one-cycle pulse: a new snapshot merged into unserved events

## Operation
**Accumulator (`accum`)**
- `accum[i]` sets on any cycle with `coll_in[i]`=1.
- On a `startOfFrame` cycle: `accum <= coll_in`. Old contents move to `serve`; same-cycle pulses are kept for the next frame.

**Serve vector (`serve`)**
- On a `startOfFrame` cycle: `serve <= (serve & ~clr) | accum`.
  - `clr` is the one-hot of `ev_id` when a handshake completes that same cycle, else 0.
- `overrun` pulses the next cycle if `(serve & ~clr)` was non-zero at the merge. Bits already pending are OR-merged; no count is kept.

**Round-robin pointer (`ptr`)**
- Range 0..N_EVENTS-1.
- The pick is the first set bit of `serve` searching from `ptr` upward, wrapping past N_EVENTS-1 to 0.
- After an accepted event k: `ptr <= k+1`, or 0 when k = N_EVENTS-1.

**FSM**
- IDLE:
  - `ev_valid`=0.
  - If `serve` ≠ 0 → ARB.
- ARB:
  - `ev_id <= pick`, `ev_valid <= 1` → PRESENT.
  - `serve` cannot be empty here.
- PRESENT:
  - `ev_valid` and `ev_id` held stable until `ev_ready`.
  - On `ev_ready`: clear `serve[ev_id]`, update `ptr`, `ev_valid <= 0`.
  - Next state is ARB if remaining `serve` (including any same-cycle merge) ≠ 0, else IDLE.
- `ev_ready` while `ev_valid`=0 is ignored.

**Other outputs**
- `busy = (serve != 0) | ev_valid`.

## Timing
- Reset values: `ev_valid`=0, `ev_id`=0, `overrun`=0, `busy`=0, `accum`=0, `serve`=0, `ptr`=0, FSM=IDLE.
- All outputs are registered.
- Latency:
  - `startOfFrame` at cycle T with non-empty `accum` loads `serve` at the edge ending T.
  - FSM reaches ARB in T+1.
  - `ev_valid` is first high in T+2.
- Throughput: one event per 2 cycles with `ev_ready` tied high (PRESENT→ARB bubble).
- Boundary cases:
  - **Event bit pulses while pending in `serve`:** it only affects `accum`. It is re-issued next frame.
  - **`startOfFrame` and `ev_ready` in the same cycle:** the clear is applied before the merge. A re-merged bit for the accepted id is legal and is not an overrun unless other bits remained.
  - **`startOfFrame` with `accum`=0 while IDLE:** no state change.
  - **`reset` mid-PRESENT:** `ev_valid` drops the next cycle. Pending events are lost and nothing is issued afterwards.
- Wrap: a pointer at N_EVENTS-1 with only bit 0 pending picks 0.

## Test plan
- **Reset:** hold `reset` 2 cycles mid-operation → all outputs 0 the cycle after. No `ev_valid` until a new frame has events.
- **Single event:**
  - `coll_in[3]` pulsed 5 times in frame, then `startOfFrame` at T, `ev_ready`=1.
  - → `ev_valid`=1, `ev_id`=3 at T+2, for exactly one cycle.
  - `busy` is 0 from T+3.
- **Round-robin order:**
  - Events 2, 7, 20 pending with `ptr`=8, `ev_ready`=1.
  - → ids issued 20, 2, 7 at T+2, T+4, T+6.
  - `ptr` ends at 8.
- **Backpressure:** `ev_ready`=0 for 10 cycles → `ev_id` stable, `ev_valid` held. Accept on cycle 11 → next event 2 cycles later.
- **Overrun:**
  - Events 1 and 4 pending, `ev_ready`=0.
  - Next `startOfFrame` with `accum` = {4, 9}.
  - → `overrun` pulses once.
  - Serve set = {1, 4, 9}; each id is issued once.
- **Same-cycle edge:**
  - `coll_in[5]` pulses in the `startOfFrame` cycle → it is issued in the following frame, not the current one.
  - Accepting id 5 in the same cycle as a merge containing 5 (no other pending) → no overrun; 5 is issued again.
